// File: rtl/lpc_synth.sv
// lpc_synth: frame-driven LPC speech synthesizer.
// Builds one excitation value per requested sample (a pitch impulse train
// or LFSR noise) and filters it through a 10th-order all-pole direct-form
// IIR using one serial multiply-accumulate, producing one 16-bit sample.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   A1..A10             signed Q3.12 predictor coefficients (a0 is 1.0)
//   voiced, freq_count  excitation mode, pitch period in samples
//   frame_valid/ready   frame load handshake (ready = not busy)
//   sample_req          one-cycle request for a new sample
//   y, y_valid          signed sample and its one-cycle strobe
//   busy, overrun       computation in progress, sticky dropped-request flag
module lpc_synth #(
  parameter int          COEF_FRAC = 12,
  parameter int          GAIN_V    = 8192,
  parameter int          GAIN_UV   = 2048,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] A1,
  input  logic signed [15:0] A2,
  input  logic signed [15:0] A3,
  input  logic signed [15:0] A4,
  input  logic signed [15:0] A5,
  input  logic signed [15:0] A6,
  input  logic signed [15:0] A7,
  input  logic signed [15:0] A8,
  input  logic signed [15:0] A9,
  input  logic signed [15:0] A10,
  input  logic               voiced,
  input  logic [15:0]        freq_count,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               sample_req,
  output logic signed [15:0] y,
  output logic               y_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {S_IDLE, S_EXC, S_MAC, S_OUT} state_t;

  state_t             r_state, w_next;
  logic signed [15:0] r_a [10];
  logic signed [15:0] r_h [10];   // r_h[k-1] holds y[n-k]
  logic               r_voiced;
  logic [15:0]        r_period;
  logic [15:0]        r_pc;
  logic [15:0]        r_lfsr;
  logic signed [35:0] r_acc;
  logic [3:0]         r_k;
  logic signed [15:0] r_y;
  logic               r_y_valid;
  logic               r_overrun;

  logic signed [15:0] w_a_in [10];
  logic               w_busy, w_load;
  logic signed [15:0] w_e;
  logic [15:0]        w_period_eff;
  logic [16:0]        w_pc_inc;
  logic [15:0]        w_pc_next;
  logic signed [31:0] w_prod;
  logic signed [35:0] w_shift;
  logic signed [15:0] w_sat;

  assign w_a_in[0] = A1;
  assign w_a_in[1] = A2;
  assign w_a_in[2] = A3;
  assign w_a_in[3] = A4;
  assign w_a_in[4] = A5;
  assign w_a_in[5] = A6;
  assign w_a_in[6] = A7;
  assign w_a_in[7] = A8;
  assign w_a_in[8] = A9;
  assign w_a_in[9] = A10;

  assign w_busy      = (r_state != S_IDLE);
  assign w_load      = frame_valid && !w_busy;
  assign busy        = w_busy;
  assign frame_ready = !w_busy;
  assign y           = r_y;
  assign y_valid     = r_y_valid;
  assign overrun     = r_overrun;

  // Periods 0 and 1 both mean "impulse every sample".
  assign w_period_eff = (r_period <= 16'd1) ? 16'd1 : r_period;
  assign w_pc_inc     = {1'b0, r_pc} + 17'd1;
  assign w_pc_next    = (w_pc_inc >= {1'b0, w_period_eff}) ? 16'd0 : w_pc_inc[15:0];

  always_comb begin
    w_e = '0;
    if (r_voiced) begin
      if (r_pc == 16'd0) w_e = 16'(GAIN_V);
    end else begin
      w_e = r_lfsr[0] ? 16'(GAIN_UV) : 16'(-GAIN_UV);
    end
  end

  assign w_prod  = r_a[r_k] * r_h[r_k];
  assign w_shift = r_acc >>> COEF_FRAC;

  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > 36'sd32767)       w_sat = 16'sh7FFF;
    else if (w_shift < -36'sd32768) w_sat = 16'sh8000;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (sample_req) w_next = S_EXC;
      S_EXC:  w_next = S_MAC;
      S_MAC:  if (r_k == 4'd9) w_next = S_OUT;
      S_OUT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) begin
        r_a[i] <= '0;
        r_h[i] <= '0;
      end
      r_voiced  <= 1'b0;
      r_period  <= '0;
      r_pc      <= '0;
      r_lfsr    <= LFSR_SEED;
      r_acc     <= '0;
      r_k       <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      if (w_load) begin
        for (int i = 0; i < 10; i++) r_a[i] <= w_a_in[i];
        r_voiced  <= voiced;
        r_period  <= freq_count;
        r_overrun <= 1'b0;
        // Only an unvoiced->voiced switch restarts the pitch phase.
        if (voiced && !r_voiced) r_pc <= '0;
      end
      if (sample_req && w_busy) r_overrun <= 1'b1;
      case (r_state)
        S_EXC: begin
          if (r_voiced) r_pc   <= w_pc_next;
          else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
          r_acc <= {{20{w_e[15]}}, w_e} <<< COEF_FRAC;
          r_k   <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc - {{4{w_prod[31]}}, w_prod};
          r_k   <= r_k + 4'd1;
        end
        S_OUT: begin
          r_y       <= w_sat;
          r_y_valid <= 1'b1;
          for (int i = 9; i > 0; i--) r_h[i] <= r_h[i-1];
          r_h[0] <= w_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_synth.sv
module tb_lpc_synth;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] ta [1:10];
  logic               voiced = 1'b0;
  logic [15:0]        freq_count = '0;
  logic               frame_valid = 1'b0;
  logic               frame_ready;
  logic               sample_req = 1'b0;
  logic signed [15:0] y;
  logic               y_valid, busy, overrun;

  int checks = 0;
  int failures = 0;

  // Behavioural reference state
  int         m_a [1:10];
  int         m_h [1:10];
  bit         m_voiced;
  int         m_period;
  int         m_pc;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  lpc_synth dut (
    .clk(clk), .rst(rst),
    .A1(ta[1]), .A2(ta[2]), .A3(ta[3]), .A4(ta[4]), .A5(ta[5]),
    .A6(ta[6]), .A7(ta[7]), .A8(ta[8]), .A9(ta[9]), .A10(ta[10]),
    .voiced(voiced), .freq_count(freq_count), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .sample_req(sample_req), .y(y),
    .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 1; k <= 10; k++) begin m_a[k] = 0; m_h[k] = 0; end
    m_voiced = 0; m_period = 0; m_pc = 0; m_lfsr = 16'hACE1;
  endfunction

  // One output sample from the rules: excitation, y = e - sum a_k*y[n-k], clamp.
  function automatic int model_step();
    int e, p, s;
    longint acc;
    if (m_voiced) begin
      e = (m_pc == 0) ? 8192 : 0;
      p = (m_period <= 1) ? 1 : m_period;
      m_pc = (m_pc + 1 >= p) ? 0 : m_pc + 1;
    end else begin
      e = m_lfsr[0] ? 2048 : -2048;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    acc = longint'(e) * 4096;
    for (int k = 1; k <= 10; k++) acc -= longint'(m_a[k]) * longint'(m_h[k]);
    acc = acc >>> 12;
    s = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : int'(acc);
    for (int k = 10; k > 1; k--) m_h[k] = m_h[k-1];
    m_h[1] = s;
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic set_a1(input int a1);
    for (int k = 1; k <= 10; k++) ta[k] = '0;
    ta[1] = 16'(a1);
  endtask

  task automatic load_frame(input bit v, input int p);
    chk("frame_ready_idle", frame_ready, 1);
    frame_valid = 1'b1; voiced = v; freq_count = 16'(p);
    @(posedge clk);
    #1 frame_valid = 1'b0;
    if (v && !m_voiced) m_pc = 0;
    m_voiced = v; m_period = p;
    for (int k = 1; k <= 10; k++) m_a[k] = int'(ta[k]);
    chk("overrun_clr_on_load", overrun, 0);
  endtask

  // Request one sample; y_valid must arrive exactly 12 edges after the request edge.
  task automatic do_req(input string tag, output int got);
    int vcnt, vat, exp;
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    vcnt = 0; vat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (y_valid) begin vcnt++; vat = i; end
      if (i == 6) chk({tag, "_busy_mid"}, busy, 1);
    end
    exp = model_step();
    chk({tag, "_latency"}, vat, 12);
    chk({tag, "_nvalid"}, vcnt, 1);
    chk({tag, "_y"}, y, exp);
    chk({tag, "_busy_end"}, busy, 0);
    got = int'(y);
  endtask

  initial begin
    int got, vcnt;
    int imp [8] = '{8192, 0, 0, 0, 8192, 0, 0, 0};
    int dec [5] = '{8192, 4096, 2048, 1024, 512};
    int sat [4] = '{8192, 16384, 32767, 32767};
    for (int k = 1; k <= 10; k++) ta[k] = '0;

    // Reset
    do_reset();
    @(posedge clk); #1;
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_ready", frame_ready, 1);
    chk("rst_overrun", overrun, 0);

    // Impulse train, period 4
    set_a1(0); load_frame(1, 4);
    for (int i = 0; i < 8; i++) begin
      do_req("imp", got);
      chk("imp_const", got, imp[i]);
    end

    // One-pole decay
    do_reset();
    set_a1(-2048); load_frame(1, 100);
    for (int i = 0; i < 5; i++) begin
      do_req("decay", got);
      chk("decay_const", got, dec[i]);
    end

    // Saturation
    do_reset();
    set_a1(-8192); load_frame(1, 100);
    for (int i = 0; i < 4; i++) begin
      do_req("sat", got);
      chk("sat_const", got, sat[i]);
    end

    // Noise
    do_reset();
    set_a1(0); load_frame(0, 0);
    for (int i = 0; i < 16; i++) begin
      do_req("noise", got);
      if (i == 0) chk("noise_first", got, 2048);
      chk("noise_mag", (got < 0) ? -got : got, 2048);
    end

    // Randomized frames, coefficients, modes and periods
    for (int f = 0; f < 6; f++) begin
      for (int k = 1; k <= 10; k++) ta[k] = 16'(int'($urandom_range(0, 2000)) - 1000);
      load_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
      for (int i = 0; i < 3; i++) do_req("rand", got);
    end

    // Overrun and blocked frame load
    do_reset();
    set_a1(-2048); load_frame(1, 3);
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    vcnt = 0;
    for (int i = 1; i <= 4; i++) begin @(posedge clk); #1; if (y_valid) vcnt++; end
    sample_req = 1'b1; frame_valid = 1'b1; voiced = 1'b0;
    ta[1] = 16'sh4000; freq_count = 16'd9;
    @(posedge clk);
    #1 sample_req = 1'b0; frame_valid = 1'b0;
    chk("ovr_frame_ready", frame_ready, 0);
    for (int i = 6; i <= 25; i++) begin @(posedge clk); #1; if (y_valid) vcnt++; end
    chk("ovr_one_valid", vcnt, 1);
    chk("ovr_y", y, model_step());
    chk("ovr_sticky", overrun, 1);
    do_req("ovr_old_frame", got);   // model still holds the earlier frame
    chk("ovr_still_set", overrun, 1);
    set_a1(-2048); load_frame(1, 3);

    // Reset in the middle of a computation
    do_req("pre_abort", got);
    chk("pre_abort_nonzero", (got != 0), 1);
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    vcnt = 0;
    for (int i = 1; i <= 6; i++) begin @(posedge clk); #1; if (y_valid) vcnt++; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("abort_y", y, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_ready", frame_ready, 1);
    chk("abort_overrun", overrun, 0);
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (y_valid) vcnt++; end
    chk("abort_no_valid", vcnt, 0);
    do_req("post_abort", got);
    chk("post_abort_const", got, 2048);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lpc_synth.md
# lpc_synth

Frame-driven LPC speech synthesizer; the decode end of the LPC encoder. It accepts one frame of 10th-order predictor coefficients, a voiced/unvoiced flag and a pitch period per frame. It generates an excitation signal (a pitch impulse train or LFSR noise) and runs it through an all-pole lattice-free direct-form IIR, producing one 16-bit sample per request. It sits between the Avalon-side coefficient source and the audio output path, and uses a single serial multiply-accumulate unit.

## Interface
Parameters:
- COEF_FRAC, 12: fractional bits of the coefficients (Q3.12, 4096 = 1.0).
- GAIN_V, 8192: voiced impulse amplitude.
- GAIN_UV, 2048: unvoiced noise magnitude.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Synchronous, active-high; clock clk.
- A1..A10, input, 16 each: signed predictor coefficients a1..a10 (Q3.12). There is no A0; it is implicitly 1.0.
- voiced, input, 1: 1 selects impulse-train excitation, 0 selects noise.
- freq_count, input, 16: unsigned pitch period in samples. Values 0 and 1 are both treated as 1.
- frame_valid, input, 1: frame load strobe.
- frame_ready, output, 1: frame can be loaded this cycle.
- sample_req, input, 1: single-cycle request for one output sample. It is already synchronous to clk.
- y, output, 16: signed synthesized sample.
- y_valid, output, 1: one-cycle strobe marking a new y.
- busy, output, 1: a sample computation is in progress.
- overrun, output, 1: sticky; a sample_req arrived while busy.

## Operation
- Frame registers (a1..a10, voiced, period) load when frame_valid && frame_ready. They are used from the next sample onward.
- frame_ready = ~busy. A frame_valid while busy is ignored; the source must hold it.
- Loading a frame with voiced=1 when the previous voiced=0 clears the pitch counter pc. Otherwise pc keeps its phase.
- State machine: IDLE → EXC → MAC → OUT → IDLE.
  - IDLE: sample_req=1 moves to EXC. Any other input keeps the state in IDLE.
  - EXC: computes the excitation e.
    - Voiced: e = GAIN_V if pc==0, else 0. Then pc ← (pc+1 ≥ period) ? 0 : pc+1.
    - Unvoiced: e = lfsr[0] ? +GAIN_UV : −GAIN_UV. Then the LFSR advances one step (Fibonacci, taps 16,14,13,11; new bit = l[15]^l[13]^l[12]^l[10], shifted into bit 0).
    - The pitch counter and the LFSR both update only in EXC, and only on the path for the current voiced mode.
    - acc ← e <<< COEF_FRAC.
  - MAC: runs 10 cycles, k = 1..10: acc ← acc − a_k · h[k], where h[k] = y[n−k]. acc is 36-bit signed; products are full 32-bit.
  - OUT: s = acc >>> COEF_FRAC (arithmetic), saturated to [−32768, 32767].
    - y ← s and y_valid ← 1.
    - History shifts: h[10..2] ← h[9..1], h[1] ← s.
- sample_req while busy is dropped and sets overrun. overrun clears only on rst or on a frame load.
- Reset values:
  - y=0, y_valid=0, busy=0, frame_ready=1, overrun=0.
  - All history h[1..10]=0, acc=0, pc=0, lfsr=LFSR_SEED.
  - Frame registers are all 0 (period treated as 1). With this frame, output equals excitation.
- rst mid-computation aborts the computation. No y_valid is produced, and the block returns to reset values on the next edge.

## Timing
- sample_req sampled high at edge t in IDLE.
  - EXC occupies t+1.
  - MAC occupies t+2..t+11.
  - OUT occupies edge t+12: y and y_valid are registered there.
  - y_valid is high for exactly one cycle, 12 clk after the request edge.
- busy is high from t+1 through t+12 inclusive. A new sample_req is accepted at edge t+13 or later.
- Maximum sample rate is clk/13.
- y holds its value between strobes.
- A simultaneous frame_valid and sample_req in IDLE: the frame loads and the sample uses the new frame.

## Test plan
- **Reset:** apply rst for 2 cycles, then idle → y=0, y_valid=0, busy=0, frame_ready=1, overrun=0.
- **Impulse train:** load coefficients all 0, voiced=1, freq_count=4, then issue 8 requests spaced 13 cycles apart → y = 8192,0,0,0,8192,0,0,0. Each y_valid arrives exactly 12 cycles after its request.
- **One-pole decay:** load A1=−2048 (−0.5), others 0, voiced=1, freq_count=100, then issue 5 requests → y = 8192,4096,2048,1024,512.
- **Saturation:** load A1=−8192 (−2.0), voiced=1, freq_count=100 → y = 8192,16384,32767,32767.
- **Noise:** after reset, load voiced=0 with coefficients 0, then issue 16 requests → y = ±2048, with the sign sequence matching a reference LFSR model seeded 16'hACE1. The first sample is +2048.
- **Overrun, blocked frame load and mid-operation reset:**
  - sample_req at t and again at t+5 → one y_valid only, and overrun=1.
  - frame_valid at t+5 → not loaded (frame_ready=0).
  - A later frame load clears overrun.
  - rst asserted at t+7 of a new request → no y_valid; all outputs return to reset values.
